// File: rtl/prover_h_chi_seq_pkg.sv
// Shared definitions for the chi sequencers: field constants, sequencer state
// encoding and the field one-minus helper.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif

package prover_h_chi_seq_pkg;

   localparam int unsigned FNbits = `F_NBITS;
   localparam logic [FNbits-1:0] FQ = `F_Q;

   typedef enum logic [3:0] {
      StIdle,
      StTau,
      StIssue,
      StWait,
      StEvChk,
      StEvWait,
      StEvIssue,
      StEvRun,
      StDone
   } seq_state_e;

   // (1 - tau) mod q for tau < q. q + 1 - tau lies in [2, q + 1], so one
   // conditional subtract brings tau = 0 to 1 and tau = 1 to 0.
   function automatic logic [FNbits-1:0] one_minus(input logic [FNbits-1:0] tau);
      logic [FNbits:0] q_wide;
      logic [FNbits:0] one_wide;
      logic [FNbits:0] wide;
      q_wide   = {1'b0, FQ};
      one_wide = {{FNbits{1'b0}}, 1'b1};
      wide     = q_wide + one_wide - {1'b0, tau};
      if (wide >= q_wide) begin
         wide = wide - q_wide;
      end
      return wide[FNbits-1:0];
   endfunction

endpackage

// File: rtl/prover_h_chi_seq_one_minus.sv
// Combinational field one-minus: m_o = (1 - tau_i) mod q.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif

module field_one_minus
   import prover_h_chi_seq_pkg::*;
(
   input  logic [`F_NBITS-1:0] tau_i,
   output logic [`F_NBITS-1:0] m_o
);

   // Pure function of the incoming tau; registered by the caller.
   always_comb begin
      m_o = one_minus(tau_i);
   end

endmodule

// File: rtl/prover_h_chi_seq.sv
// Sequencer for the h-side chi engine: one restart/load round, npoints-1
// multiply rounds, then n_evals evaluation passes paced by mv_valid/mv_ready.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif

module prover_h_chi_seq
   import prover_h_chi_seq_pkg::*;
#(
   parameter int unsigned npoints = 3,
   parameter int unsigned nevbits = 8
) (
   input  logic                clk,
   input  logic                rstb,
   input  logic                start,
   input  logic [nevbits-1:0]  n_evals,
   input  logic                tau_valid,
   input  logic [`F_NBITS-1:0] tau_data,
   output logic                tau_ready,
   input  logic                mv_valid,
   output logic                mv_ready,
   output logic                chi_en,
   output logic                chi_restart,
   output logic [`F_NBITS-1:0] chi_tau,
   output logic [`F_NBITS-1:0] chi_m_tau_p1,
   input  logic                chi_ready_pulse,
   input  logic                chi_chi_ready,
   output logic                busy,
   output logic                done_pulse
);

   localparam int unsigned CntW = $clog2(npoints) + 1;
   localparam logic [CntW-1:0] LastTau = CntW'(npoints - 1);

   seq_state_e          state_q, state_d;
   logic                start_q, start_d;
   logic [nevbits-1:0]  nev_q, nev_d;
   logic [CntW-1:0]     tau_cnt_q, tau_cnt_d;
   logic [nevbits-1:0]  ev_cnt_q, ev_cnt_d;
   logic [`F_NBITS-1:0] tau_q, tau_d;
   logic [`F_NBITS-1:0] m_q, m_d;
   logic                mv_ready_q, mv_ready_d;
   // Sticky: engine reported no complete chi table when evaluation began.
   logic                chi_err_q, chi_err_d;

   logic                start_edge;
   logic [`F_NBITS-1:0] m_new;

   assign start_edge = start & ~start_q;

   field_one_minus u_one_minus (
      .tau_i (tau_data),
      .m_o   (m_new)
   );

   // All sequencer state; start_q resets high so a held start cannot fire.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q    <= StIdle;
         start_q    <= 1'b1;
         nev_q      <= '0;
         tau_cnt_q  <= '0;
         ev_cnt_q   <= '0;
         tau_q      <= '0;
         m_q        <= '0;
         mv_ready_q <= 1'b0;
         chi_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         start_q    <= start_d;
         nev_q      <= nev_d;
         tau_cnt_q  <= tau_cnt_d;
         ev_cnt_q   <= ev_cnt_d;
         tau_q      <= tau_d;
         m_q        <= m_d;
         mv_ready_q <= mv_ready_d;
         chi_err_q  <= chi_err_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:    if (start_edge) state_d = StTau;
         StTau:     if (tau_valid) state_d = StIssue;
         StIssue:   state_d = StWait;
         StWait: begin
            if (chi_ready_pulse) begin
               state_d = (tau_cnt_q == LastTau) ? StEvChk : StTau;
            end
         end
         StEvChk:   state_d = (ev_cnt_q == nev_q) ? StDone : StEvWait;
         StEvWait:  if (mv_valid) state_d = StEvIssue;
         StEvIssue: state_d = StEvRun;
         StEvRun:   if (chi_ready_pulse) state_d = StEvChk;
         StDone:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Counters, latched operands and the mv_ready pulse.
   always_comb begin
      start_d    = start;
      nev_d      = nev_q;
      tau_cnt_d  = tau_cnt_q;
      ev_cnt_d   = ev_cnt_q;
      tau_d      = tau_q;
      m_d        = m_q;
      mv_ready_d = 1'b0;
      chi_err_d  = chi_err_q;
      case (state_q)
         StIdle: begin
            if (start_edge) begin
               nev_d     = n_evals;
               tau_cnt_d = '0;
               ev_cnt_d  = '0;
            end
         end
         StTau: begin
            if (tau_valid) begin
               tau_d = tau_data;
               m_d   = m_new;
            end
         end
         StWait: begin
            if (chi_ready_pulse) tau_cnt_d = tau_cnt_q + 1'b1;
         end
         StEvChk: begin
            if (!chi_chi_ready) chi_err_d = 1'b1;
         end
         StEvRun: begin
            if (chi_ready_pulse) begin
               mv_ready_d = 1'b1;
               ev_cnt_d   = ev_cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Moore outputs; restart stays up through the first round's wait.
   always_comb begin
      tau_ready   = (state_q == StTau);
      chi_en      = (state_q == StIssue) || (state_q == StEvIssue);
      chi_restart = ((state_q == StIssue) || (state_q == StWait)) && (tau_cnt_q == '0);
      busy        = (state_q != StIdle) && (state_q != StDone);
      done_pulse  = (state_q == StDone);
   end

   assign mv_ready     = mv_ready_q;
   assign chi_tau      = tau_q;
   assign chi_m_tau_p1 = m_q;

endmodule
